// File: rtl/dep_issue_sched_pkg.sv
// Shared definitions for the dependency-tracking issue scheduler.
//   slot_state_e : per-slot lifecycle (free -> waiting -> issued -> free)
//   DefaultBs    : default number of instruction buffer slots
//   iw_of()      : slot-index width for a given slot count
package dep_issue_sched_pkg;

    typedef enum logic [1:0] {
        SlotFree    = 2'd0,
        SlotWaiting = 2'd1,
        SlotIssued  = 2'd2
    } slot_state_e;

    localparam int unsigned DefaultBs = 16;

    // Keep at least one index bit so a degenerate slot count still elaborates.
    function automatic int unsigned iw_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dep_issue_sched_rr.sv
// rr_picker: combinational round-robin find-first.
// Searches req starting at ptr and moving upward, wrapping bs-1 -> 0.
//   req   : request vector, one bit per slot
//   ptr   : search start position
//   found : at least one request bit set
//   index : first requesting slot at or after ptr (0 when none)
module rr_picker
    import dep_issue_sched_pkg::*;
#(
    parameter int unsigned bs = DefaultBs,
    localparam int unsigned IW = iw_of(bs)
) (
    input  logic [bs-1:0] req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] index
);

    logic [IW-1:0] cand;

    // bs is a power of two, so IW-bit addition wraps exactly at bs.
    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = 0; k < int'(bs); k++) begin
            cand = ptr + IW'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/dep_issue_sched.sv
// dep_issue_sched: tracks up to bs in-flight instructions with a bs x bs
// dependency matrix and offers ready slots for issue in round-robin order.
//   clk, rst                  : clock, synchronous active-high reset
//   alloc_valid/index/idt     : write a new instruction and its dependency vector
//   complete_valid/index      : an issued instruction finished; frees its slot
//   issue_valid/ready/index   : registered issue offer with valid/ready handshake
//   slot_busy                 : bit i set when slot i is not free
//   alloc_err, cmpl_err       : one-cycle pulses for rejected alloc / complete
module dep_issue_sched
    import dep_issue_sched_pkg::*;
#(
    parameter int unsigned bs = DefaultBs,
    localparam int unsigned IW = iw_of(bs)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc_valid,
    input  logic [IW-1:0] alloc_index,
    input  logic [bs-1:0] alloc_idt,
    input  logic          complete_valid,
    input  logic [IW-1:0] complete_index,
    output logic          issue_valid,
    input  logic          issue_ready,
    output logic [IW-1:0] issue_index,
    output logic [bs-1:0] slot_busy,
    output logic          alloc_err,
    output logic          cmpl_err
);

    localparam logic [bs-1:0] OneHot0 = {{(bs-1){1'b0}}, 1'b1};

    slot_state_e   state_q [bs];
    slot_state_e   state_d [bs];
    logic [bs-1:0] dep_q   [bs];
    logic [bs-1:0] dep_d   [bs];

    logic          issue_valid_q;
    logic [IW-1:0] issue_index_q;
    logic [IW-1:0] rr_ptr_q;
    logic          alloc_err_q;
    logic          cmpl_err_q;

    logic          handshake;
    logic          cmpl_ok;
    logic          alloc_ok;
    logic [bs-1:0] alloc_self;
    logic [bs-1:0] cmpl_self;
    logic [bs-1:0] ready_vec;
    logic [IW-1:0] pick_ptr;
    logic [IW-1:0] pick_index;
    logic          pick_found;

    always_comb begin
        for (int i = 0; i < int'(bs); i++) begin
            slot_busy[i] = (state_q[i] != SlotFree);
        end
    end

    assign handshake = issue_valid_q & issue_ready;
    assign cmpl_ok   = complete_valid && (state_q[complete_index] == SlotIssued);
    // A slot freed by a completion on this same edge may be reallocated immediately.
    assign alloc_ok  = alloc_valid && ((state_q[alloc_index] == SlotFree) ||
                                       (cmpl_ok && (complete_index == alloc_index)));

    assign alloc_self = OneHot0 << alloc_index;
    assign cmpl_self  = cmpl_ok ? (OneHot0 << complete_index) : '0;

    // Completion is applied before allocation so a same-slot alloc wins.
    always_comb begin
        for (int i = 0; i < int'(bs); i++) begin
            state_d[i] = state_q[i];
            dep_d[i]   = dep_q[i];
        end
        if (cmpl_ok) begin
            state_d[complete_index] = SlotFree;
            for (int i = 0; i < int'(bs); i++) begin
                dep_d[i] = dep_d[i] & ~cmpl_self;
            end
        end
        if (handshake) begin
            state_d[issue_index_q] = SlotIssued;
        end
        if (alloc_ok) begin
            state_d[alloc_index] = SlotWaiting;
            // Only live producers count; free slots, self and the slot retiring now are dropped.
            dep_d[alloc_index]   = alloc_idt & slot_busy & ~alloc_self & ~cmpl_self;
        end
    end

    // The slot being handed off this edge must not be picked again.
    always_comb begin
        for (int i = 0; i < int'(bs); i++) begin
            ready_vec[i] = (state_q[i] == SlotWaiting) && (dep_q[i] == '0) &&
                           !(handshake && (issue_index_q == IW'(i)));
        end
    end

    assign pick_ptr = handshake ? (issue_index_q + IW'(1)) : rr_ptr_q;

    rr_picker #(
        .bs (bs)
    ) u_rr_picker (
        .req   (ready_vec),
        .ptr   (pick_ptr),
        .found (pick_found),
        .index (pick_index)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(bs); i++) begin
                state_q[i] <= SlotFree;
                dep_q[i]   <= '0;
            end
            issue_valid_q <= 1'b0;
            issue_index_q <= '0;
            rr_ptr_q      <= '0;
            alloc_err_q   <= 1'b0;
            cmpl_err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < int'(bs); i++) begin
                state_q[i] <= state_d[i];
                dep_q[i]   <= dep_d[i];
            end
            // The offer is held stable until accepted.
            if (!issue_valid_q || handshake) begin
                issue_valid_q <= pick_found;
                issue_index_q <= pick_index;
            end
            if (handshake) begin
                rr_ptr_q <= pick_ptr;
            end
            alloc_err_q <= alloc_valid && !alloc_ok;
            cmpl_err_q  <= complete_valid && !cmpl_ok;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_index = issue_index_q;
    assign alloc_err   = alloc_err_q;
    assign cmpl_err    = cmpl_err_q;

endmodule

// File: tb/tb_dep_issue_sched.sv
// Scoreboard bench for dep_issue_sched: directed stimulus pushes expected issue
// indices and error pulses into queues; a negedge monitor pops and compares.
module tb_dep_issue_sched;

    localparam int unsigned BS = 16;
    localparam int unsigned IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_valid;
    logic [IW-1:0] alloc_index;
    logic [BS-1:0] alloc_idt;
    logic          complete_valid;
    logic [IW-1:0] complete_index;
    logic          issue_valid;
    logic          issue_ready;
    logic [IW-1:0] issue_index;
    logic [BS-1:0] slot_busy;
    logic          alloc_err;
    logic          cmpl_err;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_issue_q[$];
    int exp_err_q[$];   // 1 = alloc_err, 2 = cmpl_err

    dep_issue_sched #(
        .bs (BS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_valid    (alloc_valid),
        .alloc_index    (alloc_index),
        .alloc_idt      (alloc_idt),
        .complete_valid (complete_valid),
        .complete_index (complete_index),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_index    (issue_index),
        .slot_busy      (slot_busy),
        .alloc_err      (alloc_err),
        .cmpl_err       (cmpl_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input int idx, input int idt);
        alloc_valid = 1'b1;
        alloc_index = IW'(idx);
        alloc_idt   = BS'(idt);
        step();
        alloc_valid = 1'b0;
        alloc_idt   = '0;
    endtask

    task automatic do_cmpl(input int idx);
        complete_valid = 1'b1;
        complete_index = IW'(idx);
        step();
        complete_valid = 1'b0;
    endtask

    task automatic accept(input int idx);
        exp_issue_q.push_back(idx);
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
    endtask

    // Monitor: compare every handshake and every error pulse against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (issue_valid && issue_ready) begin
                if (exp_issue_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL issue_unexpected: got index %0d, expected none", issue_index);
                end else begin
                    check("issue_order", int'(issue_index), exp_issue_q.pop_front());
                end
            end
            if (alloc_err || cmpl_err) begin
                if (exp_err_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL err_unexpected: got alloc_err=%0b cmpl_err=%0b, expected none",
                             alloc_err, cmpl_err);
                end else begin
                    check("err_pulse", int'({cmpl_err, alloc_err}), exp_err_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        alloc_valid    = 1'b0;
        alloc_index    = '0;
        alloc_idt      = '0;
        complete_valid = 1'b0;
        complete_index = '0;
        issue_ready    = 1'b0;
        step();
        step();
        check("rst_issue_valid", int'(issue_valid), 0);
        check("rst_issue_index", int'(issue_index), 0);
        check("rst_slot_busy", int'(slot_busy), 0);
        check("rst_errs", int'({cmpl_err, alloc_err}), 0);
        rst = 1'b0;

        // Alloc slot 3 with no deps: offered two edges after the alloc.
        do_alloc(3, 0);
        check("a3_busy", int'(slot_busy), 'h0008);
        check("a3_not_yet", int'(issue_valid), 0);
        step();
        check("a3_valid", int'(issue_valid), 1);
        check("a3_index", int'(issue_index), 3);
        accept(3);
        do_cmpl(3);
        check("a3_freed", int'(slot_busy), 0);

        // Slot 2 depends on slot 1; offer of 1 is held under back-pressure.
        do_alloc(1, 0);
        do_alloc(2, 'h0002);
        for (int c = 0; c < 3; c++) begin
            check("hold_valid", int'(issue_valid), 1);
            check("hold_index", int'(issue_index), 1);
            step();
        end
        accept(1);
        for (int c = 0; c < 2; c++) begin
            check("dep_blocked", int'(issue_valid), 0);
            step();
        end
        do_cmpl(1);
        check("release_edge", int'(issue_valid), 0);
        step();
        check("release_valid", int'(issue_valid), 1);
        check("release_index", int'(issue_index), 2);
        accept(2);
        do_cmpl(2);

        // Errors: alloc to waiting slot 4 keeps its deps; complete of free slot 7.
        do_alloc(8, 0);
        step();
        check("e8_index", int'(issue_index), 8);
        accept(8);
        do_alloc(4, 'h0100);
        exp_err_q.push_back(1);
        do_alloc(4, 0);
        for (int c = 0; c < 2; c++) begin
            check("e4_still_blocked", int'(issue_valid), 0);
            step();
        end
        exp_err_q.push_back(2);
        do_cmpl(7);
        step();
        do_cmpl(8);
        step();
        check("e4_valid", int'(issue_valid), 1);
        check("e4_index", int'(issue_index), 4);
        accept(4);
        do_cmpl(4);

        // Same-edge complete 6 and realloc 6; self bit and free-slot bit are masked.
        do_alloc(6, 0);
        step();
        accept(6);
        complete_valid = 1'b1;
        complete_index = 4'd6;
        alloc_valid    = 1'b1;
        alloc_index    = 4'd6;
        alloc_idt      = 16'h0440;
        step();
        complete_valid = 1'b0;
        alloc_valid    = 1'b0;
        alloc_idt      = '0;
        check("same_busy", int'(slot_busy), 'h0040);
        step();
        check("same_valid", int'(issue_valid), 1);
        check("same_index", int'(issue_index), 6);
        accept(6);
        do_cmpl(6);

        // Round-robin: park rr_ptr at 6, then release 0, 5, 9 together.
        do_alloc(15, 0);
        step();
        accept(15);
        do_alloc(5, 0);
        step();
        accept(5);
        do_cmpl(5);
        do_alloc(0, 'h8000);
        do_alloc(5, 'h8000);
        do_alloc(9, 'h8000);
        check("rr_blocked", int'(issue_valid), 0);
        exp_issue_q.push_back(9);
        exp_issue_q.push_back(0);
        exp_issue_q.push_back(5);
        issue_ready = 1'b1;
        do_cmpl(15);
        for (int c = 0; c < 10; c++) begin
            if (exp_issue_q.size() == 0) break;
            step();
        end
        issue_ready = 1'b0;
        check("rr_drained", exp_issue_q.size(), 0);
        do_cmpl(0);
        do_cmpl(5);
        do_cmpl(9);

        // Reset mid-flight overrides a concurrent bad alloc.
        do_alloc(2, 0);
        do_alloc(3, 'h0004);
        check("pre_rst_valid", int'(issue_valid), 1);
        rst         = 1'b1;
        alloc_valid = 1'b1;
        alloc_index = 4'd2;
        step();
        rst         = 1'b0;
        alloc_valid = 1'b0;
        check("mid_rst_valid", int'(issue_valid), 0);
        check("mid_rst_index", int'(issue_index), 0);
        check("mid_rst_busy", int'(slot_busy), 0);
        check("mid_rst_errs", int'({cmpl_err, alloc_err}), 0);
        step();
        check("post_rst_idle", int'(issue_valid), 0);

        check("issue_q_empty", exp_issue_q.size(), 0);
        check("err_q_empty", exp_err_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
